// File: rtl/peri_pkg.sv
// Shared definitions for the peri output buffer: FSM state encoding,
// buffer geometry constants and the packed entry type.
package peri_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } out_buf_state_e;

  localparam int OB_NUM_ADC = 8;
  localparam int OB_ADC_W   = 8;
  localparam int OB_LANE_W  = 16;
  localparam int OB_DEPTH   = 16;
  localparam int OB_PTR_W   = $clog2(OB_DEPTH * OB_NUM_ADC * OB_LANE_W / 32);

  // One conversion: NUM_ADC lanes, lane 0 in the least significant bits.
  typedef logic [OB_NUM_ADC-1:0][OB_LANE_W-1:0] ob_entry_t;

endpackage

// File: rtl/peri_out_sat_add.sv
// One lane of the accumulate path: adds a zero-extended ADC result to a
// stored lane and clamps the sum at the lane's all-ones value.
module peri_out_sat_add #(
  parameter int LANE_W = 16,
  parameter int ADC_W  = 8
) (
  input  logic [LANE_W-1:0] i_acc,
  input  logic [ADC_W-1:0]  i_adc,
  output logic [LANE_W-1:0] o_sum
);

  logic [LANE_W:0] w_sum;

  // Widen by one bit so the carry out marks saturation.
  always_comb begin
    w_sum = {1'b0, i_acc} + {{(LANE_W + 1 - ADC_W){1'b0}}, i_adc};
    if (w_sum[LANE_W]) begin
      o_sum = '1;
    end else begin
      o_sum = w_sum[LANE_W-1:0];
    end
  end

endmodule

// File: rtl/peri_out_buffer.sv
// PIM output buffer: captures ADC conversions into a small entry array
// during a PIM operation and serves them as 32-bit words to the CPU side.
// Build option: define PERI_OUT_BUF_ACCUM_EN to accumulate (saturating)
// across passes with exec_cnt_i != 0 instead of overwriting.
import peri_pkg::*;

module peri_out_buffer (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          pim_en_i,
  input  logic [3:0]                    exec_cnt_i,
  input  logic                          adc_valid_i,
  input  logic [OB_NUM_ADC*OB_ADC_W-1:0] adc_data_i,
  input  logic                          out_buf_read_i,
  input  logic [OB_PTR_W-1:0]           read_ptr_i,
  output logic [31:0]                   data_o,
  output logic                          data_valid_o,
  output logic [$clog2(OB_DEPTH):0]     entry_cnt_o,
  output logic                          full_o,
  output logic                          ovf_o,
  output logic                          done_o
);

  localparam int NUM_ADC = OB_NUM_ADC;
  localparam int ADC_W   = OB_ADC_W;
  localparam int LANE_W  = OB_LANE_W;
  localparam int DEPTH   = OB_DEPTH;
  localparam int WSEL_W  = $clog2(NUM_ADC * LANE_W / 32);
  localparam int EIDX_W  = $clog2(DEPTH);
  localparam int CNT_W   = EIDX_W + 1;

  out_buf_state_e   r_state;
  logic             r_pim_en_q;
  ob_entry_t        r_mem [DEPTH];
  logic [CNT_W-1:0] r_entry_cnt;
  logic             r_full;
  logic             r_ovf;
  logic             r_done;
  logic [31:0]      r_data;
  logic             r_data_valid;

  logic                      w_start;
  logic                      w_keep;
  logic [EIDX_W-1:0]         w_wr_idx;
  logic [EIDX_W-1:0]         w_rd_idx;
  logic [WSEL_W-1:0]         w_rd_sel;
  logic [NUM_ADC*LANE_W-1:0] w_rd_flat;
  logic [31:0]               w_rd_word;
  ob_entry_t                 w_new_entry;

  // A start is a sampled rising edge of pim_en_i outside CAPTURE.
  assign w_start  = pim_en_i & ~r_pim_en_q & (r_state != CAPTURE);
  assign w_wr_idx = r_entry_cnt[EIDX_W-1:0];
  assign w_rd_idx = read_ptr_i[OB_PTR_W-1:WSEL_W];
  assign w_rd_sel = read_ptr_i[WSEL_W-1:0];
  assign w_rd_flat = r_mem[w_rd_idx];
  assign w_rd_word = w_rd_flat[{w_rd_sel, 5'd0} +: 32];

`ifdef PERI_OUT_BUF_ACCUM_EN
  ob_entry_t w_old_entry;

  assign w_old_entry = r_mem[w_wr_idx];
  // Later passes keep the previous results to accumulate onto.
  assign w_keep      = (exec_cnt_i != 4'd0);

  for (genvar k = 0; k < NUM_ADC; k++) begin : g_sat
    peri_out_sat_add #(
      .LANE_W (LANE_W),
      .ADC_W  (ADC_W)
    ) u_sat (
      .i_acc (w_old_entry[k]),
      .i_adc (adc_data_i[k*ADC_W +: ADC_W]),
      .o_sum (w_new_entry[k])
    );
  end
`else
  logic w_unused_exec;

  assign w_keep        = 1'b0;
  assign w_unused_exec = ^exec_cnt_i;

  // Each capture overwrites the entry with zero-extended ADC results.
  always_comb begin
    w_new_entry = '0;
    for (int k = 0; k < NUM_ADC; k++) begin
      w_new_entry[k] = {{(LANE_W - ADC_W){1'b0}}, adc_data_i[k*ADC_W +: ADC_W]};
    end
  end
`endif

  // Control FSM, entry array and registered read port in one sequential process.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= IDLE;
      r_pim_en_q   <= 1'b0;
      r_entry_cnt  <= '0;
      r_full       <= 1'b0;
      r_ovf        <= 1'b0;
      r_done       <= 1'b0;
      r_data       <= 32'd0;
      r_data_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_pim_en_q   <= pim_en_i;
      r_data_valid <= out_buf_read_i;
      // Read sees the pre-edge array, so a same-cycle write returns old data.
      if (out_buf_read_i) begin
        r_data <= w_rd_word;
      end
      if (w_start) begin
        r_state     <= CAPTURE;
        r_entry_cnt <= '0;
        r_full      <= 1'b0;
        r_ovf       <= 1'b0;
        r_done      <= 1'b0;
        if (!w_keep) begin
          for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
          end
        end
      end else begin
        case (r_state)
          CAPTURE: begin
            if (adc_valid_i) begin
              if (!r_full) begin
                r_mem[w_wr_idx] <= w_new_entry;
                r_entry_cnt     <= r_entry_cnt + CNT_W'(1);
                r_full          <= ((r_entry_cnt + CNT_W'(1)) == CNT_W'(DEPTH));
              end else begin
                r_ovf <= 1'b1;
              end
            end
            if (!pim_en_i) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
          default: begin
            r_state <= r_state;
          end
        endcase
      end
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_data_valid;
  assign entry_cnt_o  = r_entry_cnt;
  assign full_o       = r_full;
  assign ovf_o        = r_ovf;
  assign done_o       = r_done;

endmodule

// File: tb/tb_peri_out_buffer.sv
// Self-checking bench for peri_out_buffer with a behavioural reference model.
module tb_peri_out_buffer;

`ifdef PERI_OUT_BUF_ACCUM_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        pim_en_i = 1'b0;
  logic [3:0]  exec_cnt_i = 4'd0;
  logic        adc_valid_i = 1'b0;
  logic [63:0] adc_data_i = 64'd0;
  logic        out_buf_read_i = 1'b0;
  logic [5:0]  read_ptr_i = 6'd0;
  logic [31:0] data_o;
  logic        data_valid_o;
  logic [4:0]  entry_cnt_o;
  logic        full_o;
  logic        ovf_o;
  logic        done_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int          m_mem [16][8];
  int          m_cnt;
  bit          m_ovf, m_done, m_active, m_prev, m_dv;
  logic [31:0] m_data;

  peri_out_buffer dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .pim_en_i       (pim_en_i),
    .exec_cnt_i     (exec_cnt_i),
    .adc_valid_i    (adc_valid_i),
    .adc_data_i     (adc_data_i),
    .out_buf_read_i (out_buf_read_i),
    .read_ptr_i     (read_ptr_i),
    .data_o         (data_o),
    .data_valid_o   (data_valid_o),
    .entry_cnt_o    (entry_cnt_o),
    .full_o         (full_o),
    .ovf_o          (ovf_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] m_word(input int w);
    int e, s;
    logic [15:0] lo, hi;
    e  = w / 4;
    s  = w % 4;
    lo = 16'(m_mem[e][2*s]);
    hi = 16'(m_mem[e][2*s+1]);
    return {hi, lo};
  endfunction

  task automatic m_reset();
    for (int e = 0; e < 16; e++)
      for (int k = 0; k < 8; k++) m_mem[e][k] = 0;
    m_cnt = 0; m_ovf = 0; m_done = 0; m_active = 0; m_prev = 0; m_dv = 0;
    m_data = 32'd0;
  endtask

  // What one clock edge does to the model, from the buffer's rules.
  task automatic m_edge();
    int v, s;
    if (out_buf_read_i) m_data = m_word(int'(read_ptr_i));
    m_dv = out_buf_read_i;
    if (pim_en_i && !m_prev && !m_active) begin
      m_active = 1; m_cnt = 0; m_ovf = 0; m_done = 0;
      if (!(ACC && exec_cnt_i != 4'd0))
        for (int e = 0; e < 16; e++)
          for (int k = 0; k < 8; k++) m_mem[e][k] = 0;
    end else if (m_active) begin
      if (adc_valid_i) begin
        if (m_cnt < 16) begin
          for (int k = 0; k < 8; k++) begin
            v = int'(adc_data_i[k*8 +: 8]);
            if (ACC) begin
              s = m_mem[m_cnt][k] + v;
              m_mem[m_cnt][k] = (s > 65535) ? 65535 : s;
            end else begin
              m_mem[m_cnt][k] = v;
            end
          end
          m_cnt++;
        end else begin
          m_ovf = 1;
        end
      end
      if (!pim_en_i) begin m_active = 0; m_done = 1; end
    end
    m_prev = pim_en_i;
  endtask

  // Drive one cycle of inputs, advance the model, settle at the falling edge.
  task automatic step(input logic pim, input logic [3:0] ex, input logic vld,
                      input logic [63:0] dat, input logic rd, input logic [5:0] ptr);
    pim_en_i = pim; exec_cnt_i = ex; adc_valid_i = vld; adc_data_i = dat;
    out_buf_read_i = rd; read_ptr_i = ptr;
    @(posedge clk_i);
    m_edge();
    @(negedge clk_i);
  endtask

  function automatic logic [63:0] ramp(input logic [7:0] base);
    logic [63:0] d;
    for (int k = 0; k < 8; k++) d[k*8 +: 8] = base + 8'(k);
    return d;
  endfunction

  function automatic logic [63:0] fill(input logic [7:0] b);
    return {8{b}};
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    m_reset();
    repeat (2) @(negedge clk_i);
    n_vec++; if (data_o !== 32'd0) begin n_err++; $display("FAIL reset_data got %h want 0", data_o); end
    n_vec++; if (data_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_dv got %b want 0", data_valid_o); end
    n_vec++; if (entry_cnt_o !== 5'd0 || full_o !== 1'b0 || ovf_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL reset_flags got cnt=%0d full=%b ovf=%b done=%b want 0", entry_cnt_o, full_o, ovf_o, done_o);
    end
    rst_ni = 1'b1;
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1, 6'd37);
    n_vec++; if (data_o !== 32'd0 || data_valid_o !== 1'b1) begin
      n_err++; $display("FAIL reset_read got %h dv=%b want 0 dv=1", data_o, data_valid_o);
    end
  endtask

  task automatic test_basic_capture();
    step(1'b1, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd0, 1'b1, ramp(8'h10), 1'b0, 6'd0);
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    n_vec++; if (done_o !== 1'b1 || entry_cnt_o !== 5'd3) begin
      n_err++; $display("FAIL basic_done got done=%b cnt=%0d want 1/3", done_o, entry_cnt_o);
    end
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1, 6'd0);
    n_vec++; if (data_o !== 32'h0011_0010 || data_valid_o !== 1'b1) begin
      n_err++; $display("FAIL basic_ptr0 got %h dv=%b want 00110010", data_o, data_valid_o);
    end
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1, 6'd11);
    n_vec++; if (data_o !== 32'h0017_0016) begin n_err++; $display("FAIL basic_ptr11 got %h want 00170016", data_o); end
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    n_vec++; if (data_o !== 32'h0017_0016 || data_valid_o !== 1'b0) begin
      n_err++; $display("FAIL basic_hold got %h dv=%b want 00170016 dv=0", data_o, data_valid_o);
    end
  endtask

  task automatic test_overflow();
    step(1'b1, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    for (int i = 1; i <= 17; i++) begin
      step(1'b1, 4'd0, 1'b1, {$urandom, $urandom}, 1'b0, 6'd0);
      if (i == 15 || i == 16) begin
        n_vec++; if (full_o !== (i == 16)) begin n_err++; $display("FAIL ovf_full%0d got %b want %b", i, full_o, (i == 16)); end
      end
      if (i == 16 || i == 17) begin
        n_vec++; if (ovf_o !== (i == 17)) begin n_err++; $display("FAIL ovf_flag%0d got %b want %b", i, ovf_o, (i == 17)); end
      end
    end
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    for (int w = 60; w < 64; w++) begin
      step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1, 6'(w));
      n_vec++; if (data_o !== m_data) begin n_err++; $display("FAIL ovf_entry15 w%0d got %h want %h", w, data_o, m_data); end
    end
  endtask

  task automatic test_restart_clear();
    step(1'b1, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    step(1'b1, 4'd0, 1'b1, ramp(8'h40), 1'b0, 6'd0);
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1, 6'd4);
    n_vec++; if (data_o !== 32'd0 || ovf_o !== 1'b0 || entry_cnt_o !== 5'd1) begin
      n_err++; $display("FAIL restart got %h ovf=%b cnt=%0d want 0/0/1", data_o, ovf_o, entry_cnt_o);
    end
  endtask

  task automatic test_accumulate();
    logic [31:0] want;
    step(1'b1, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    step(1'b1, 4'd0, 1'b1, fill(8'hFF), 1'b0, 6'd0);
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    step(1'b1, 4'd1, 1'b0, 64'd0, 1'b0, 6'd0);
    step(1'b1, 4'd1, 1'b1, fill(8'h02), 1'b0, 6'd0);
    step(1'b0, 4'd1, 1'b0, 64'd0, 1'b1, 6'd0);
    want = ACC ? 32'h0101_0101 : 32'h0002_0002;
    n_vec++; if (data_o !== want) begin n_err++; $display("FAIL accum_pass1 got %h want %h", data_o, want); end
    // Build 0xFFF0 per lane: one fresh pass of F0, then 256 passes of FF.
    for (int p = 0; p < 257; p++) begin
      step(1'b1, (p == 0) ? 4'd0 : 4'd3, 1'b0, 64'd0, 1'b0, 6'd0);
      step(1'b1, (p == 0) ? 4'd0 : 4'd3, 1'b1, fill((p == 0) ? 8'hF0 : 8'hFF), 1'b0, 6'd0);
      step(1'b0, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    end
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1, 6'd2);
    want = ACC ? 32'hFFF0_FFF0 : 32'h00FF_00FF;
    n_vec++; if (data_o !== want) begin n_err++; $display("FAIL accum_preset got %h want %h", data_o, want); end
    step(1'b1, 4'd2, 1'b0, 64'd0, 1'b0, 6'd0);
    step(1'b1, 4'd2, 1'b1, fill(8'h20), 1'b0, 6'd0);
    step(1'b0, 4'd2, 1'b0, 64'd0, 1'b1, 6'd3);
    want = ACC ? 32'hFFFF_FFFF : 32'h0020_0020;
    n_vec++; if (data_o !== want) begin n_err++; $display("FAIL accum_sat got %h want %h", data_o, want); end
  endtask

  task automatic test_collision();
    step(1'b1, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    step(1'b1, 4'd0, 1'b1, ramp(8'h81), 1'b1, 6'd0);
    n_vec++; if (data_o !== 32'd0 || entry_cnt_o !== 5'd1) begin
      n_err++; $display("FAIL collide_old got %h cnt=%0d want 0/1", data_o, entry_cnt_o);
    end
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1, 6'd0);
    n_vec++; if (data_o !== 32'h0082_0081) begin n_err++; $display("FAIL collide_new got %h want 00820081", data_o); end
    step(1'b1, 4'd0, 1'b1, ramp(8'h33), 1'b0, 6'd0);
    n_vec++; if (entry_cnt_o !== 5'd0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL start_valid got cnt=%0d done=%b want 0/0", entry_cnt_o, done_o);
    end
    step(1'b0, 4'd0, 1'b0, 64'd0, 1'b1, 6'd1);
    n_vec++; if (data_o !== 32'd0) begin n_err++; $display("FAIL start_valid_data got %h want 0", data_o); end
  endtask

  task automatic test_random();
    int nv, gap_pct;
    logic [3:0] ex;
    for (int op = 0; op < 12; op++) begin
      ex = 4'($urandom_range(0, 2));
      nv = $urandom_range(0, 20);
      gap_pct = $urandom_range(0, 50);
      step(1'b1, ex, $urandom_range(0, 1) == 1, {$urandom, $urandom}, 1'b0, 6'd0);
      while (nv > 0) begin
        logic v;
        v = ($urandom_range(0, 99) >= gap_pct);
        if (v) nv--;
        step(1'b1, ex, v, {$urandom, $urandom}, $urandom_range(0, 1) == 1, 6'($urandom));
        n_vec++; if (data_o !== m_data || data_valid_o !== m_dv) begin
          n_err++; $display("FAIL rand_read got %h/%b want %h/%b", data_o, data_valid_o, m_data, m_dv);
        end
        n_vec++; if (entry_cnt_o !== 5'(m_cnt) || full_o !== (m_cnt == 16) || ovf_o !== m_ovf || done_o !== m_done) begin
          n_err++; $display("FAIL rand_flags got %0d/%b/%b/%b want %0d/%b/%b/%b", entry_cnt_o, full_o, ovf_o, done_o,
                            m_cnt, (m_cnt == 16), m_ovf, m_done);
        end
      end
      step(1'b0, ex, 1'b0, 64'd0, 1'b0, 6'd0);
      for (int r = 0; r < 6; r++) begin
        step(1'b0, ex, $urandom_range(0, 1) == 1, {$urandom, $urandom}, 1'b1, 6'($urandom));
        n_vec++; if (data_o !== m_data || done_o !== 1'b1 || entry_cnt_o !== 5'(m_cnt)) begin
          n_err++; $display("FAIL rand_done got %h d=%b c=%0d want %h d=1 c=%0d", data_o, done_o, entry_cnt_o, m_data, m_cnt);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 4'd0, 1'b0, 64'd0, 1'b0, 6'd0);
    step(1'b1, 4'd0, 1'b1, ramp(8'h55), 1'b0, 6'd0);
    step(1'b1, 4'd0, 1'b1, ramp(8'h66), 1'b1, 6'd0);
    #2 rst_ni = 1'b0;
    #1;
    n_vec++; if (data_o !== 32'd0 || data_valid_o !== 1'b0 || entry_cnt_o !== 5'd0 ||
                 full_o !== 1'b0 || ovf_o !== 1'b0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL rst_mid got %h dv=%b cnt=%0d want all 0", data_o, data_valid_o, entry_cnt_o);
    end
    m_reset();
    @(negedge clk_i);
    rst_ni = 1'b1;
    step(1'b0, 4'd0, 1'b1, ramp(8'h77), 1'b1, 6'd0);
    n_vec++; if (entry_cnt_o !== 5'd0 || data_o !== 32'd0 || done_o !== 1'b0) begin
      n_err++; $display("FAIL rst_idle got cnt=%0d data=%h done=%b want 0/0/0", entry_cnt_o, data_o, done_o);
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic_capture();
    test_overflow();
    test_restart_clear();
    test_accumulate();
    test_collision();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
